regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register address width (16 entries).
REQ-003 The block SHALL have parameter LOCK_MAX, default 8, meaning maximum consecutive locked grants before forced release.
REQ-004 The block SHALL have port clk, input, 1, meaning the clock.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have ports req_valid, req_write and req_lock, each input, 2, meaning per-client request, write-not-read and lock-hold.
REQ-007 The block SHALL have port req_ready, output, 2, meaning per-client grant; a transfer occurs when valid and ready are both high.
REQ-008 The block SHALL have ports req_addr_a and req_addr_b, each input, 2*ADDR_W, meaning per-client packed addresses (client n at slice n).
REQ-009 The block SHALL have port req_wdata, input, 2*DATA_W, meaning per-client packed write data.
REQ-010 The block SHALL have port rsp_valid, output, 2, meaning a one-cycle read-response strobe per client.
REQ-011 The block SHALL have ports rsp_data_a and rsp_data_b, each output, 2*DATA_W, meaning per-client packed read data.
REQ-012 The block SHALL have ports rf_read_address1, rf_read_address2 and rf_write_address, each output, ADDR_W, meaning the register-file addresses.
REQ-013 The block SHALL have ports rf_write_enable, output, 1, and rf_write_data, output, DATA_W, meaning the register-file write port.
REQ-014 The block SHALL have ports rf_read_data1 and rf_read_data2, each input, DATA_W, meaning register-file read data, registered one cycle after the address.

Function
REQ-015 At most one req_ready bit SHALL be high per cycle; req_ready is combinational from req_valid, FSM state and the priority pointer.
REQ-016 The FSM SHALL have states ARB and LOCKED; in ARB, arbitration is round-robin: the pointer names the favoured client, and after every transfer it moves to the other client.
REQ-017 A transfer with req_lock[n]=1 in ARB SHALL move the FSM to LOCKED(n) and load lock_cnt=1.
REQ-018 In LOCKED(n), only client n SHALL be eligible; each locked transfer increments lock_cnt.
REQ-019 LOCKED(n) SHALL return to ARB when any of these occurs: a transfer with lock=0; req_valid[n]=0; or lock_cnt reaches LOCK_MAX (forced release, pointer set to the other client).
REQ-020 On a read transfer in cycle k, rf_read_address1/2 SHALL equal addr_a/addr_b in cycle k, and rf_write_enable=0.
REQ-021 For a read transfer in cycle k, rsp_valid[n] SHALL be 1 in cycle k+1 only, with rsp_data_a/b slice n = rf_read_data1/2; non-responding slices read 0.
REQ-022 On a write transfer, rf_write_enable=1, rf_write_address=addr_a and rf_write_data=wdata SHALL be driven in the same cycle; writes produce no response.
REQ-023 Back-to-back read transfers SHALL yield back-to-back responses (throughput 1 per cycle); the response tag (client id) is pipelined one stage.
REQ-024 A read granted in the cycle after a write to the same address SHALL return the new data; no stall is inserted.
REQ-025 In cycles with no transfer, all rf_* outputs SHALL be driven to 0.

Reset
REQ-026 While reset is high: FSM=ARB, pointer=client 0, lock_cnt=0, req_ready=0, rsp_valid=0, rsp_data=0, and rf_write_enable=0.
REQ-027 A reset asserted with a read in flight SHALL drop that response; no rsp_valid follows the deassertion.

Structure
REQ-028 DATA_W/ADDR_W defaults and the FSM state encoding (ARB, LOCKED) SHALL live in the shared CPU package.
REQ-029 A round-robin two-way arbiter sub-module, rr_arb2 (req[1:0] + pointer -> one-hot grant), SHALL be instantiated; the lock FSM stays in the top level.

Verification
REQ-030 Both clients hold reads of R3/R4 with R3=0x11 and R4=0x22 -> grants alternate 0,1,0,1; each rsp_valid arrives 1 cycle after its grant with data 0x11/0x22.
REQ-031 Client 0 writes R5=0xA5, then client 1 reads R5 in the next cycle -> rsp_data_a[1]=0xA5 in the following cycle.
REQ-032 Client 1 locks with continuous valid while client 0 requests -> exactly 8 consecutive client-1 grants, then client 0 is granted.
REQ-033 A locked client drops valid after 3 grants -> client 0 is granted the next cycle.
REQ-034 Reset asserted in the cycle after a read grant -> rsp_valid stays 0, and all outputs are 0 during reset.
REQ-035 Single-client reads with no contention -> ready is high every cycle, with 16 responses in 16 cycles.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// Shared CPU package for the register-file arbiter.
// Holds the default widths, the lock FSM state encoding and a
// client-id to one-hot helper used by the arbiter and the lock FSM.
package regfile_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Client id (0/1) to one-hot request/grant vector.
  function automatic logic [1:0] client_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (combinational).
// Ports:
//   req   - per-client request vector
//   ptr   - favoured client id; it wins when both clients request
//   grant - one-hot grant, zero when nothing is requested
module rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Favoured client first, otherwise the other one.
  always_comb begin
    grant = 2'b00;
    if (req[ptr]) begin
      grant = client_onehot(ptr);
    end else if (req[!ptr]) begin
      grant = client_onehot(!ptr);
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-client register-file access arbiter with bounded lock-hold.
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   req_valid/req_write/req_lock      - per-client request, write-not-read, lock-hold
//   req_ready                         - per-client grant (combinational, one-hot or zero)
//   req_addr_a/req_addr_b/req_wdata   - per-client packed address/data (client n at slice n)
//   rsp_valid, rsp_data_a/rsp_data_b  - read response strobe and packed data, one cycle after grant
//   rf_read_address1/2, rf_write_*    - register-file ports, driven in the grant cycle
//   rf_read_data1/2                   - register-file read data, one cycle after the address
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [1:0]          req_lock,
  output logic [1:0]          req_ready,
  input  logic [2*ADDR_W-1:0] req_addr_a,
  input  logic [2*ADDR_W-1:0] req_addr_b,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data_a,
  output logic [2*DATA_W-1:0] rsp_data_b,
  output logic [ADDR_W-1:0]   rf_read_address1,
  output logic [ADDR_W-1:0]   rf_read_address2,
  output logic [ADDR_W-1:0]   rf_write_address,
  output logic                rf_write_enable,
  output logic [DATA_W-1:0]   rf_write_data,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

  logic              owner_held;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              xfer;
  logic              gid;
  logic              sel_write;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr_a;
  logic [ADDR_W-1:0] sel_addr_b;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  cnt_inc;

  // A lock only restricts eligibility while its owner keeps requesting;
  // once the owner drops valid the other client can win in that same cycle.
  always_comb begin
    owner_held = (state_q == LOCKED) && req_valid[owner_q];
    eligible   = req_valid;
    if (owner_held) begin
      eligible = req_valid & client_onehot(owner_q);
    end
    if (reset) begin
      eligible = 2'b00;
    end
  end

  rr_arb2 u_rr_arb2 (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign gid       = grant[1];

  // Winner's request fields.
  always_comb begin
    sel_write  = gid ? req_write[1] : req_write[0];
    sel_lock   = gid ? req_lock[1]  : req_lock[0];
    sel_addr_a = gid ? req_addr_a[2*ADDR_W-1:ADDR_W] : req_addr_a[ADDR_W-1:0];
    sel_addr_b = gid ? req_addr_b[2*ADDR_W-1:ADDR_W] : req_addr_b[ADDR_W-1:0];
    sel_wdata  = gid ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
  end

  // Register-file ports; all zero when nothing transfers.
  always_comb begin
    rf_read_address1 = '0;
    rf_read_address2 = '0;
    rf_write_address = '0;
    rf_write_enable  = 1'b0;
    rf_write_data    = '0;
    if (xfer) begin
      if (sel_write) begin
        rf_write_enable  = 1'b1;
        rf_write_address = sel_addr_a;
        rf_write_data    = sel_wdata;
      end else begin
        rf_read_address1 = sel_addr_a;
        rf_read_address2 = sel_addr_b;
      end
    end
  end

  // Lock FSM next state; pointer always moves past the client just served.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + CNT_W'(1);
    if (xfer) begin
      ptr_d = !gid;
      if (owner_held) begin
        if (!sel_lock || (cnt_inc == CNT_W'(LOCK_MAX))) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = cnt_inc;
        end
      end else if (sel_lock && (CNT_W'(LOCK_MAX) != CNT_W'(1))) begin
        state_d    = LOCKED;
        owner_d    = gid;
        lock_cnt_d = CNT_W'(1);
      end else begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end else if (state_q == LOCKED) begin
      state_d    = ARB;
      lock_cnt_d = '0;
    end
  end

  // State registers and the one-stage response tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      lock_cnt_q <= '0;
      rsp_valid  <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_valid  <= (xfer && !sel_write) ? grant : 2'b00;
    end
  end

  // Steer register-file read data into the responding client's slice.
  always_comb begin
    rsp_data_a = '0;
    rsp_data_b = '0;
    if (rsp_valid[0]) begin
      rsp_data_a[DATA_W-1:0] = rf_read_data1;
      rsp_data_b[DATA_W-1:0] = rf_read_data2;
    end
    if (rsp_valid[1]) begin
      rsp_data_a[2*DATA_W-1:DATA_W] = rf_read_data1;
      rsp_data_b[2*DATA_W-1:DATA_W] = rf_read_data2;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: stimulus pushes one expected record
// per cycle; a negedge monitor pops and compares grant, rf bus and responses.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid, req_write, req_lock, req_ready, rsp_valid;
  logic [7:0]  req_addr_a, req_addr_b;
  logic [15:0] req_wdata, rsp_data_a, rsp_data_b;
  logic [3:0]  rf_read_address1, rf_read_address2, rf_write_address;
  logic        rf_write_enable;
  logic [7:0]  rf_write_data, rf_read_data1, rf_read_data2;

  regfile_arbiter #(.DATA_W(8), .ADDR_W(4), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rf_read_address1(rf_read_address1), .rf_read_address2(rf_read_address2),
    .rf_write_address(rf_write_address), .rf_write_enable(rf_write_enable),
    .rf_write_data(rf_write_data),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  always #5 clk = ~clk;

  // Initial register contents: R3=0x11, R4=0x22, others 0x80|index.
  function automatic logic [7:0] init_val(input int i);
    if (i == 3) return 8'h11;
    if (i == 4) return 8'h22;
    return 8'h80 | 8'(i);
  endfunction

  // Contents after client 0 writes R5=0xA5.
  function automatic logic [7:0] exp_f(input int i);
    if (i == 5) return 8'hA5;
    return init_val(i);
  endfunction

  // External register file: registered read, synchronous write.
  logic [7:0] rf_mem [16];
  logic       rf_load = 1'b1;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= init_val(i);
    end else if (rf_write_enable) begin
      rf_mem[rf_write_address] <= rf_write_data;
    end
    rf_read_data1 <= rf_mem[rf_read_address1];
    rf_read_data2 <= rf_mem[rf_read_address2];
  end

  typedef struct packed {
    logic [1:0]  ready;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [1:0]  nrv;
    logic [15:0] nra;
    logic [15:0] nrb;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected behaviour for one cycle: g<0 means no grant.
  task automatic expect_cycle(input int g, input logic wr, input logic [3:0] aa,
                              input logic [3:0] ab, input logic [7:0] wd,
                              input logic [7:0] da, input logic [7:0] db);
    exp_t e;
    e = '0;
    if (g >= 0) begin
      e.ready = (g == 1) ? 2'b10 : 2'b01;
      if (wr) begin
        e.we = 1'b1;
        e.wa = aa;
        e.wd = wd;
      end else begin
        e.ra1 = aa;
        e.ra2 = ab;
        e.nrv = e.ready;
        e.nra = (g == 1) ? {da, 8'h00} : {8'h00, da};
        e.nrb = (g == 1) ? {db, 8'h00} : {8'h00, db};
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic set_client(input int n, input logic v, input logic w, input logic l,
                            input logic [3:0] aa, input logic [3:0] ab, input logic [7:0] wd);
    req_valid[n]         = v;
    req_write[n]         = w;
    req_lock[n]          = l;
    req_addr_a[n*4 +: 4] = aa;
    req_addr_b[n*4 +: 4] = ab;
    req_wdata[n*8 +: 8]  = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_client(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
      set_client(1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
      expect_cycle(-1, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00);
      step();
    end
  endtask

  // Monitor: response expectation is pipelined one cycle behind its grant.
  exp_t        cur;
  logic [1:0]  p_rv = 2'b00;
  logic [15:0] p_ra = '0, p_rb = '0;
  always @(negedge clk) begin
    if (reset) begin
      check("reset_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_data", 64'({rsp_data_a, rsp_data_b}), 64'd0);
      check("reset_rf_we", 64'(rf_write_enable), 64'd0);
      p_rv = 2'b00; p_ra = '0; p_rb = '0;
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(p_rv));
      check("rsp_data", 64'({rsp_data_a, rsp_data_b}), 64'({p_ra, p_rb}));
      p_rv = 2'b00; p_ra = '0; p_rb = '0;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("ready", 64'(req_ready), 64'(cur.ready));
        check("rf_bus",
              64'({rf_write_enable, rf_write_address, rf_write_data, rf_read_address1, rf_read_address2}),
              64'({cur.we, cur.wa, cur.wd, cur.ra1, cur.ra2}));
        p_rv = cur.nrv; p_ra = cur.nra; p_rb = cur.nrb;
      end
    end
  end

  initial begin
    req_valid = '0; req_write = '0; req_lock = '0;
    req_addr_a = '0; req_addr_b = '0; req_wdata = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rf_load = 1'b0;
    reset = 1'b0;
    step();

    // Both clients read R3/R4: grants alternate 0,1,0,1.
    set_client(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 8'h00);
    set_client(1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 8'h00);
    for (int k = 0; k < 4; k++) begin
      expect_cycle(k % 2, 1'b0, 4'd3, 4'd4, 8'h00, 8'h11, 8'h22);
      step();
    end
    idle(2);

    // Client 0 writes R5=0xA5, client 1 reads it the next cycle.
    set_client(0, 1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 8'hA5);
    set_client(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    expect_cycle(0, 1'b1, 4'd5, 4'd0, 8'hA5, 8'h00, 8'h00);
    step();
    set_client(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    set_client(1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3, 8'h00);
    expect_cycle(1, 1'b0, 4'd5, 4'd3, 8'h00, 8'hA5, 8'h11);
    step();
    idle(2);

    // Client 1 holds lock: 8 consecutive grants, then client 0.
    set_client(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 8'h00);
    set_client(1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd3, 8'h00);
    expect_cycle(0, 1'b0, 4'd3, 4'd4, 8'h00, 8'h11, 8'h22);
    step();
    for (int k = 0; k < 8; k++) begin
      expect_cycle(1, 1'b0, 4'd4, 4'd3, 8'h00, 8'h22, 8'h11);
      step();
    end
    expect_cycle(0, 1'b0, 4'd3, 4'd4, 8'h00, 8'h11, 8'h22);
    step();
    idle(2);

    // Locked client 1 drops valid after 3 grants: client 0 next cycle.
    set_client(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 8'h00);
    set_client(1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd3, 8'h00);
    for (int k = 0; k < 3; k++) begin
      expect_cycle(1, 1'b0, 4'd4, 4'd3, 8'h00, 8'h22, 8'h11);
      step();
    end
    set_client(1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd3, 8'h00);
    expect_cycle(0, 1'b0, 4'd3, 4'd4, 8'h00, 8'h11, 8'h22);
    step();
    idle(2);

    // Reset in the cycle after a read grant drops the response.
    set_client(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 8'h00);
    set_client(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    expect_cycle(0, 1'b0, 4'd3, 4'd4, 8'h00, 8'h11, 8'h22);
    step();
    reset = 1'b1;
    set_client(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    step();
    step();
    reset = 1'b0;
    idle(3);

    // Single-client streaming reads: 16 grants, 16 responses.
    set_client(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      set_client(0, 1'b1, 1'b0, 1'b0, 4'(i), 4'(15 - i), 8'h00);
      expect_cycle(0, 1'b0, 4'(i), 4'(15 - i), 8'h00, exp_f(i), exp_f(15 - i));
      step();
    end
    idle(2);

    // Client 1 write uses its own data slice; client 0 reads it back.
    set_client(0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 8'h33);
    set_client(1, 1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 8'h5C);
    expect_cycle(1, 1'b1, 4'd9, 4'd0, 8'h5C, 8'h00, 8'h00);
    step();
    set_client(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    set_client(0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd5, 8'h00);
    expect_cycle(0, 1'b0, 4'd9, 4'd5, 8'h00, 8'h5C, 8'hA5);
    step();
    idle(2);

    step();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
